ar_xbar: RTL and testbench

Parametrised AXI read-address (AR) channel crossbar: NUM_MASTERS masters onto NUM_SLAVES slaves, with round-robin arbitration, base/mask address decode and one registered output stage. It sits inside the AXI interconnect between the master-side AR ports and the slave-side AR ports. It replaces the fixed 2x3 combinational arbiter/decoder pair. Payload is broadcast on one shared slave bus; ARVALID is per slave. The master index is prepended to ARID so the R channel can route responses back.

---
 rtl/ar_xbar_pkg.sv | 47 ++++
 rtl/ar_xbar_if.sv | 51 +++++
 rtl/ar_xbar_arb.sv | 34 +++
 rtl/ar_xbar.sv | 132 +++++++++++++
 tb/tb_ar_xbar.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ar_xbar_pkg.sv
// Shared types, default widths/address map and the slave decode helper for the AR crossbar.
package axi_xbar_pkg;

    typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} ar_state_e;

    localparam int DEF_NUM_MASTERS = 2;
    localparam int DEF_NUM_SLAVES  = 3;
    localparam int DEF_ID_BITS     = 4;
    localparam int DEF_MID_BITS    = 4;
    localparam int DEF_ADDR_BITS   = 32;
    localparam int DEF_LEN_BITS    = 4;
    localparam int DEF_SIZE_BITS   = 3;
    localparam int BURST_BITS      = 2;

    // Slave s occupies slice s: slave 0 at 0x0000_0000, slave 2 at 0x0002_0000.
    localparam logic [DEF_NUM_SLAVES*DEF_ADDR_BITS-1:0] DEF_SLV_BASE =
        {32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [DEF_NUM_SLAVES*DEF_ADDR_BITS-1:0] DEF_SLV_MASK = {3{32'hFFFF_0000}};

    // Decode tables are sized for the largest supported map; callers zero-extend.
    localparam int MAX_SLAVES    = 16;
    localparam int MAX_ADDR_BITS = 64;

    typedef logic [MAX_SLAVES-1:0][MAX_ADDR_BITS-1:0] slv_tbl_t;

    typedef struct packed {
        logic [MAX_SLAVES-1:0] onehot;
        logic                  miss;
    } dec_t;

    function automatic dec_t decode(input logic [MAX_ADDR_BITS-1:0] addr,
                                    input slv_tbl_t base,
                                    input slv_tbl_t mask,
                                    input int nslv);
        dec_t d;
        d.onehot = '0;
        d.miss   = 1'b1;
        for (int s = 0; s < MAX_SLAVES; s++) begin
            if (d.miss && (s < nslv) && ((addr & mask[s]) == base[s])) begin
                d.onehot[s] = 1'b1;
                d.miss      = 1'b0;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/ar_xbar_if.sv
// AR channel bundle between the masters, the crossbar and the slaves.
// Default-slave handshake exists only with AXI_AR_DEFAULT_SLAVE_EN.
interface ar_xbar_if
    import axi_xbar_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
    parameter int ID_BITS     = DEF_ID_BITS,
    parameter int MID_BITS    = DEF_MID_BITS,
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int LEN_BITS    = DEF_LEN_BITS,
    parameter int SIZE_BITS   = DEF_SIZE_BITS
);
    logic [NUM_MASTERS-1:0][ID_BITS-1:0]    ARID_M;
    logic [NUM_MASTERS-1:0][ADDR_BITS-1:0]  ARADDR_M;
    logic [NUM_MASTERS-1:0][LEN_BITS-1:0]   ARLEN_M;
    logic [NUM_MASTERS-1:0][SIZE_BITS-1:0]  ARSIZE_M;
    logic [NUM_MASTERS-1:0][BURST_BITS-1:0] ARBURST_M;
    logic [NUM_MASTERS-1:0]                 ARVALID_M;
    logic [NUM_MASTERS-1:0]                 ARREADY_M;

    logic [MID_BITS+ID_BITS-1:0]            ARID_S;
    logic [ADDR_BITS-1:0]                   ARADDR_S;
    logic [LEN_BITS-1:0]                    ARLEN_S;
    logic [SIZE_BITS-1:0]                   ARSIZE_S;
    logic [BURST_BITS-1:0]                  ARBURST_S;
    logic [NUM_SLAVES-1:0]                  ARVALID_S;
    logic [NUM_SLAVES-1:0]                  ARREADY_S;
`ifdef AXI_AR_DEFAULT_SLAVE_EN
    logic                                   ARVALID_DS;
    logic                                   ARREADY_DS;
`endif

    // Traffic side: drives master requests and slave readies.
    modport master (
`ifdef AXI_AR_DEFAULT_SLAVE_EN
        input  ARVALID_DS, output ARREADY_DS,
`endif
        output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, ARREADY_S,
        input  ARREADY_M, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S
    );

    // Crossbar side.
    modport slave (
`ifdef AXI_AR_DEFAULT_SLAVE_EN
        output ARVALID_DS, input ARREADY_DS,
`endif
        input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, ARREADY_S,
        output ARREADY_M, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S
    );
endinterface

// File: rtl/ar_xbar_arb.sv
// Round-robin arbiter: search starts one past the last granted requester.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    logic [IW-1:0] r_last;
    logic          w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!w_found && req[(int'(r_last) + k) % N]) begin
                w_found                        = 1'b1;
                grant[(int'(r_last) + k) % N]  = 1'b1;
                grant_idx                      = IW'((int'(r_last) + k) % N);
            end
        end
    end

    // Reset to N-1 so requester 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!rst)              r_last <= IW'(N - 1);
        else if (en && |req)   r_last <= grant_idx;
    end
endmodule

// File: rtl/ar_xbar.sv
// AXI AR crossbar: round-robin over masters, base/mask decode, one registered output slot.
// AXI_AR_DEFAULT_SLAVE_EN routes unmapped addresses to a separate default-slave handshake.
module ar_xbar
    import axi_xbar_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
    parameter int ID_BITS     = DEF_ID_BITS,
    parameter int MID_BITS    = DEF_MID_BITS,
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int LEN_BITS    = DEF_LEN_BITS,
    parameter int SIZE_BITS   = DEF_SIZE_BITS,
    parameter logic [NUM_SLAVES*ADDR_BITS-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLAVES*ADDR_BITS-1:0] SLV_MASK = DEF_SLV_MASK
) (
    input  logic     clk,
    input  logic     rst,
    ar_xbar_if.slave bus
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    ar_state_e                   r_state;
    logic [NUM_SLAVES-1:0]       r_sel;
    logic [MID_BITS+ID_BITS-1:0] r_id;
    logic [ADDR_BITS-1:0]        r_addr;
    logic [LEN_BITS-1:0]         r_len;
    logic [SIZE_BITS-1:0]        r_size;
    logic [BURST_BITS-1:0]       r_burst;

    logic                        w_slave_hs;
    logic                        w_acc;
    logic                        w_en;
    logic [NUM_MASTERS-1:0]      w_grant;
    logic [IW-1:0]               w_gidx;
    slv_tbl_t                    w_base;
    slv_tbl_t                    w_mask;
    dec_t                        w_dec;
    logic [NUM_SLAVES-1:0]       w_route;

`ifdef AXI_AR_DEFAULT_SLAVE_EN
    logic                        r_ds;
    assign w_slave_hs = (r_state == HOLD) && ((|(r_sel & bus.ARREADY_S)) || (r_ds && bus.ARREADY_DS));
    assign bus.ARVALID_DS = r_ds;
`else
    assign w_slave_hs = (r_state == HOLD) && (|(r_sel & bus.ARREADY_S));
`endif

    assign w_acc = (r_state == EMPTY) || w_slave_hs;
    assign w_en  = rst && w_acc;

    rr_arbiter #(.N(NUM_MASTERS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.ARVALID_M),
        .en        (w_en),
        .grant     (w_grant),
        .grant_idx (w_gidx)
    );

    // Ready is a function of valids and the slave handshake only, never of the address.
    assign bus.ARREADY_M = w_en ? w_grant : '0;

    always_comb begin
        w_base = '0;
        w_mask = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            w_base[s] = MAX_ADDR_BITS'(SLV_BASE[s*ADDR_BITS +: ADDR_BITS]);
            w_mask[s] = MAX_ADDR_BITS'(SLV_MASK[s*ADDR_BITS +: ADDR_BITS]);
        end
    end

    assign w_dec = decode(MAX_ADDR_BITS'(bus.ARADDR_M[w_gidx]), w_base, w_mask, NUM_SLAVES);

    generate
        if (NUM_SLAVES < MAX_SLAVES) begin : g_unused
            logic w_unused_dec;
            assign w_unused_dec = ^w_dec.onehot[MAX_SLAVES-1:NUM_SLAVES];
        end
    endgenerate

    always_comb begin
        w_route = w_dec.onehot[NUM_SLAVES-1:0];
`ifndef AXI_AR_DEFAULT_SLAVE_EN
        if (w_dec.miss) begin
            w_route                 = '0;
            w_route[NUM_SLAVES-1]   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= EMPTY;
            r_sel   <= '0;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
`ifdef AXI_AR_DEFAULT_SLAVE_EN
            r_ds    <= 1'b0;
`endif
        end else if (w_acc) begin
            if (|bus.ARVALID_M) begin
                r_state <= HOLD;
                r_sel   <= w_route;
                r_id    <= {MID_BITS'(w_gidx), bus.ARID_M[w_gidx]};
                r_addr  <= bus.ARADDR_M[w_gidx];
                r_len   <= bus.ARLEN_M[w_gidx];
                r_size  <= bus.ARSIZE_M[w_gidx];
                r_burst <= bus.ARBURST_M[w_gidx];
`ifdef AXI_AR_DEFAULT_SLAVE_EN
                r_ds    <= w_dec.miss;
`endif
            end else begin
                r_state <= EMPTY;
                r_sel   <= '0;
`ifdef AXI_AR_DEFAULT_SLAVE_EN
                r_ds    <= 1'b0;
`endif
            end
        end
    end

    // r_sel is cleared whenever the slot empties, so it doubles as the valid vector.
    assign bus.ARVALID_S = r_sel;
    assign bus.ARID_S    = r_id;
    assign bus.ARADDR_S  = r_addr;
    assign bus.ARLEN_S   = r_len;
    assign bus.ARSIZE_S  = r_size;
    assign bus.ARBURST_S = r_burst;
endmodule

// File: tb/tb_ar_xbar.sv
// Directed bench for ar_xbar with a master-to-slave scoreboard on the AR handshakes.
module tb_ar_xbar;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ar_xbar_if bus ();

    ar_xbar dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [2:0]  sel;
        logic        ds;
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } exp_t;

    exp_t q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference map: 64 KiB windows, slave = addr[31:16] for windows 0..2.
    function automatic logic [3:0] model_route(input logic [31:0] a);
        case (a[31:16])
            16'h0000: return 4'b0001;
            16'h0001: return 4'b0010;
            16'h0002: return 4'b0100;
`ifdef AXI_AR_DEFAULT_SLAVE_EN
            default:  return 4'b1000;
`else
            default:  return 4'b0100;
`endif
        endcase
    endfunction

    // Pop on slave handshake, then push on master handshake (both happen at the next posedge).
    always @(negedge clk) begin
        logic shs;
        exp_t e;
        logic [3:0] r;
        if (!rst) begin
            q.delete();
        end else begin
            shs = |(bus.ARVALID_S & bus.ARREADY_S);
`ifdef AXI_AR_DEFAULT_SLAVE_EN
            shs = shs | (bus.ARVALID_DS & bus.ARREADY_DS);
`endif
            if (shs) begin
                check("sb_nonempty", 64'(q.size() > 0), 64'(1));
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("sb_valid_s", 64'(bus.ARVALID_S), 64'(e.sel));
`ifdef AXI_AR_DEFAULT_SLAVE_EN
                    check("sb_valid_ds", 64'(bus.ARVALID_DS), 64'(e.ds));
`endif
                    check("sb_id", 64'(bus.ARID_S), 64'(e.id));
                    check("sb_addr", 64'(bus.ARADDR_S), 64'(e.addr));
                    check("sb_len_size_burst", 64'({bus.ARLEN_S, bus.ARSIZE_S, bus.ARBURST_S}),
                          64'({e.len, e.size, e.burst}));
                end
            end
            if ($countones(bus.ARREADY_M) > 1) check("ready_onehot", 64'(bus.ARREADY_M), 64'(0));
            for (int m = 0; m < 2; m++) begin
                if (bus.ARVALID_M[m] && bus.ARREADY_M[m]) begin
                    r       = model_route(bus.ARADDR_M[m]);
                    e.sel   = r[2:0];
                    e.ds    = r[3];
                    e.id    = {4'(m), bus.ARID_M[m]};
                    e.addr  = bus.ARADDR_M[m];
                    e.len   = bus.ARLEN_M[m];
                    e.size  = bus.ARSIZE_M[m];
                    e.burst = bus.ARBURST_M[m];
                    q.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int k;
        for (k = 0; k < 30; k++) begin
            if (q.size() == 0) break;
            tick();
        end
        check(tag, 64'(q.size()), 64'(0));
    endtask

    task automatic set_m(input int m, input logic [3:0] id, input logic [31:0] a, input logic [3:0] len);
        bus.ARID_M[m]    = id;
        bus.ARADDR_M[m]  = a;
        bus.ARLEN_M[m]   = len;
        bus.ARSIZE_M[m]  = 3'd2;
        bus.ARBURST_M[m] = 2'd1;
    endtask

    initial begin
        bus.ARVALID_M = 2'b11;
        bus.ARREADY_S = 3'b111;
`ifdef AXI_AR_DEFAULT_SLAVE_EN
        bus.ARREADY_DS = 1'b1;
`endif
        set_m(0, 4'h1, 32'h0000_0000, 4'd0);
        set_m(1, 4'h2, 32'h0001_0000, 4'd1);

        // Reset held for 3 cycles with both masters requesting.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ready_m", 64'(bus.ARREADY_M), 64'(0));
            check("rst_valid_s", 64'(bus.ARVALID_S), 64'(0));
            check("rst_payload", 64'({bus.ARID_S, bus.ARLEN_S, bus.ARSIZE_S, bus.ARBURST_S}), 64'(0));
            check("rst_addr", 64'(bus.ARADDR_S), 64'(0));
        end
        rst = 1'b1;
        #1;
        check("first_grant_m0", 64'(bus.ARREADY_M), 64'(2'b01));
        tick();
        bus.ARVALID_M = 2'b00;
        drain("drain_reset");

        // Single request from M1.
        set_m(1, 4'h3, 32'h0001_0040, 4'd3);
        bus.ARVALID_M = 2'b10;
        #1;
        check("single_ready", 64'(bus.ARREADY_M), 64'(2'b10));
        tick();
        bus.ARVALID_M = 2'b00;
        #1;
        check("single_valid_s", 64'(bus.ARVALID_S), 64'(3'b010));
        check("single_id_s", 64'(bus.ARID_S), 64'(8'h13));
        check("single_len_s", 64'(bus.ARLEN_S), 64'(4'd3));
        tick();
        check("single_idle", 64'(bus.ARVALID_S), 64'(0));
        drain("drain_single");

        // Round robin, both masters always valid, slaves always ready.
        set_m(0, 4'hA, 32'h0002_0008, 4'd5);
        set_m(1, 4'hB, 32'h0000_0010, 4'd7);
        bus.ARVALID_M = 2'b11;
        #1;
        for (int i = 0; i < 8; i++) begin
            check("rr_grant", 64'(bus.ARREADY_M), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            if (i > 0) check("rr_b2b_valid", 64'(bus.ARVALID_S), (i % 2 == 1) ? 64'(3'b100) : 64'(3'b001));
            tick();
        end
        bus.ARVALID_M = 2'b00;
        drain("drain_rr");

        // Back-pressure from slave 0 for 5 cycles.
        bus.ARREADY_S = 3'b110;
        set_m(0, 4'h5, 32'h0000_0100, 4'd2);
        bus.ARVALID_M = 2'b01;
        tick();
        set_m(0, 4'h6, 32'h0001_0200, 4'd4);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_s", 64'(bus.ARVALID_S), 64'(3'b001));
            check("bp_addr_s", 64'(bus.ARADDR_S), 64'(32'h0000_0100));
            check("bp_id_s", 64'(bus.ARID_S), 64'(8'h05));
            check("bp_ready_m", 64'(bus.ARREADY_M), 64'(0));
            tick();
        end
        bus.ARREADY_S = 3'b111;
        #1;
        check("bp_same_cycle_accept", 64'(bus.ARREADY_M), 64'(2'b01));
        tick();
        bus.ARVALID_M = 2'b00;
        #1;
        check("bp_next_valid_s", 64'(bus.ARVALID_S), 64'(3'b010));
        check("bp_next_addr_s", 64'(bus.ARADDR_S), 64'(32'h0001_0200));
        drain("drain_bp");

        // Unmapped address.
        set_m(1, 4'h7, 32'h0010_0000, 4'd0);
        bus.ARVALID_M = 2'b10;
        #1;
        check("unmapped_accept", 64'(bus.ARREADY_M), 64'(2'b10));
        tick();
        bus.ARVALID_M = 2'b00;
        #1;
`ifdef AXI_AR_DEFAULT_SLAVE_EN
        check("unmapped_valid_s", 64'(bus.ARVALID_S), 64'(3'b000));
        check("unmapped_valid_ds", 64'(bus.ARVALID_DS), 64'(1));
`else
        check("unmapped_valid_s", 64'(bus.ARVALID_S), 64'(3'b100));
`endif
        drain("drain_unmapped");

        // Reset while holding a stalled request.
        bus.ARREADY_S = 3'b000;
        set_m(0, 4'h9, 32'h0000_0300, 4'd1);
        bus.ARVALID_M = 2'b01;
        tick();
        bus.ARVALID_M = 2'b00;
        tick();
        check("midrst_hold", 64'(bus.ARVALID_S), 64'(3'b001));
        rst = 1'b0;
        tick();
        check("midrst_cleared", 64'(bus.ARVALID_S), 64'(0));
        rst = 1'b1;
        bus.ARREADY_S = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_stale", 64'(bus.ARVALID_S), 64'(0));
        end
        check("midrst_addr_zero", 64'(bus.ARADDR_S), 64'(0));
        check("midrst_sb_empty", 64'(q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
